// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path:
// FSM states, instruction classes, opcode/funct values and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        WB_ALU,
        MEM_ADDR,
        MEM_RD,
        WB_MEM,
        MEM_WR,
        BRANCH,
        JUMP
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_JR,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_ADDI,
        CLS_J,
        CLS_JAL,
        CLS_NONE
    } instCls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] REGDST_RT    = 2'd0;
    localparam logic [1:0] REGDST_RD    = 2'd1;
    localparam logic [1:0] REGDST_R31   = 2'd2;

    localparam logic [1:0] REGSRC_PC4   = 2'd0;
    localparam logic [1:0] REGSRC_MEM   = 2'd1;
    localparam logic [1:0] REGSRC_ALU   = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_SUB    = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

    function automatic logic functSupported(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class, whether the opcode is supported, and whether the R-type funct is an ALU op.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instCls_t   instCls,
    output logic       opLegal,
    output logic       functLegal
);

    always_comb begin
        instCls    = CLS_NONE;
        opLegal    = 1'b1;
        functLegal = functSupported(funct);
        case (opcode)
            OP_RTYPE: instCls = (funct == FN_JR) ? CLS_JR : CLS_R;
            OP_LW:    instCls = CLS_LW;
            OP_SW:    instCls = CLS_SW;
            OP_BEQ:   instCls = CLS_BEQ;
            OP_BNE:   instCls = CLS_BNE;
            OP_ADDI:  instCls = CLS_ADDI;
            OP_J:     instCls = CLS_J;
            OP_JAL:   instCls = CLS_JAL;
            default:  opLegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath selects and strobes, counts retired instructions.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memReady,
    output logic             memReq,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic [1:0]       regDst,
    output logic [1:0]       regSrc,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             regWrite,
    output logic             memWrite,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_t   state, nextState;
    instCls_t decCls, curCls;
    logic     opLegal, functLegal, functOk;
    logic     retire, flagIllegal;

    mips_ctrl_decode uDecode (
        .opcode     (opcode),
        .funct      (funct),
        .instCls    (decCls),
        .opLegal    (opLegal),
        .functLegal (functLegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Class is captured in DECODE so later states do not depend on the IR staying put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curCls  <= CLS_NONE;
            functOk <= 1'b0;
        end else if (state == DECODE) begin
            curCls  <= decCls;
            functOk <= functLegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
            if (flagIllegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState   = state;
        retire      = 1'b0;
        flagIllegal = 1'b0;
        case (state)
            FETCH: begin
                if (memReady) nextState = DECODE;
            end
            DECODE: begin
                if (!opLegal) begin
                    flagIllegal = 1'b1;
                    nextState   = FETCH;
                end else begin
                    case (decCls)
                        CLS_R:                  nextState = EXEC_R;
                        CLS_ADDI:               nextState = EXEC_I;
                        CLS_LW, CLS_SW:         nextState = MEM_ADDR;
                        CLS_BEQ, CLS_BNE:       nextState = BRANCH;
                        CLS_J, CLS_JAL, CLS_JR: nextState = JUMP;
                        default:                nextState = FETCH;
                    endcase
                end
            end
            EXEC_R: begin
                if (functOk) begin
                    nextState = WB_ALU;
                end else begin
                    flagIllegal = 1'b1;
                    nextState   = FETCH;
                end
            end
            EXEC_I:   nextState = WB_ALU;
            MEM_ADDR: nextState = (curCls == CLS_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (memReady) nextState = WB_MEM;
            end
            MEM_WR: begin
                if (memReady) begin
                    nextState = FETCH;
                    retire    = 1'b1;
                end
            end
            WB_ALU, WB_MEM, BRANCH, JUMP: begin
                nextState = FETCH;
                retire    = 1'b1;
            end
            default: nextState = FETCH;
        endcase
    end

    // Everything is forced idle while rst is high, including the FETCH request.
    always_comb begin
        memReq   = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = PCSRC_PC4;
        regDst   = REGDST_RT;
        regSrc   = REGSRC_PC4;
        ALUSrc   = 1'b0;
        ALUOp    = ALUOP_ADD;
        regWrite = 1'b0;
        memWrite = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                EXEC_R: begin
                    ALUOp  = ALUOP_FUNCT;
                    regDst = REGDST_RD;
                end
                EXEC_I: begin
                    ALUSrc = 1'b1;
                end
                WB_ALU: begin
                    regWrite = 1'b1;
                    regSrc   = REGSRC_ALU;
                    if (curCls == CLS_R) begin
                        regDst = REGDST_RD;
                        ALUOp  = ALUOP_FUNCT;
                    end else begin
                        ALUSrc = 1'b1;
                    end
                end
                MEM_ADDR: begin
                    ALUSrc = 1'b1;
                end
                MEM_RD: begin
                    memReq = 1'b1;
                    ALUSrc = 1'b1;
                end
                WB_MEM: begin
                    regWrite = 1'b1;
                    regSrc   = REGSRC_MEM;
                end
                MEM_WR: begin
                    memReq   = 1'b1;
                    ALUSrc   = 1'b1;
                    memWrite = memReady;
                end
                BRANCH: begin
                    ALUOp   = ALUOP_SUB;
                    pcSrc   = PCSRC_BRANCH;
                    pcWrite = (curCls == CLS_BNE) ? !zero : zero;
                end
                JUMP: begin
                    pcWrite = 1'b1;
                    if (curCls == CLS_JR) begin
                        pcSrc = PCSRC_REG;
                    end else begin
                        pcSrc = PCSRC_JUMP;
                        if (curCls == CLS_JAL) begin
                            regWrite = 1'b1;
                            regDst   = REGDST_R31;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: per-instruction step plans built from the
// instruction rules, random memReady/zero stimulus, plus directed latency/reset checks.
module tb_mips_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, funct;
    logic          zero, memReady;
    logic          memReq, irWrite, pcWrite, ALUSrc, regWrite, memWrite, illegal;
    logic [1:0]    pcSrc, regDst, regSrc, ALUOp;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .memReady (memReady),
        .memReq   (memReq),
        .irWrite  (irWrite),
        .pcWrite  (pcWrite),
        .pcSrc    (pcSrc),
        .regDst   (regDst),
        .regSrc   (regSrc),
        .ALUSrc   (ALUSrc),
        .ALUOp    (ALUOp),
        .regWrite (regWrite),
        .memWrite (memWrite),
        .retired  (retired),
        .illegal  (illegal)
    );

    typedef struct packed {
        logic       memReq;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic [1:0] regDst;
        logic [1:0] regSrc;
        logic       ALUSrc;
        logic [1:0] ALUOp;
        logic       regWrite;
        logic       memWrite;
    } outs_t;

    // One step = one or more cycles; a waitMem step repeats until memReady.
    typedef struct {
        bit    waitMem;
        outs_t o;
        outs_t onReady;
        int    zeroRule;   // 0 none, 1 pcWrite=zero, 2 pcWrite=!zero
    } step_t;

    outs_t         dutOut;
    outs_t         expOut;
    logic [CW-1:0] expRetired;
    logic          expIllegal;
    bit            checkEn = 0;
    step_t         plan[$];
    bit            planRetires, planIllegal;
    int            checks = 0;
    int            failures = 0;

    assign dutOut = {memReq, irWrite, pcWrite, pcSrc, regDst, regSrc, ALUSrc, ALUOp, regWrite, memWrite};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("outputs", 32'(dutOut), 32'(expOut));
            check("retired", 32'(retired), 32'(expRetired));
            check("illegal", 32'(illegal), 32'(expIllegal));
        end
    end

    function automatic step_t mkStep(input bit w, input outs_t o, input outs_t r, input int zr);
        step_t s;
        s.waitMem  = w;
        s.o        = o;
        s.onReady  = r;
        s.zeroRule = zr;
        return s;
    endfunction

    task automatic buildPlan(input logic [5:0] op, input logic [5:0] fn);
        outs_t z, o, r;
        z = '0;
        plan.delete();
        planRetires = 1;
        planIllegal = 0;
        o = z; o.memReq = 1;
        r = z; r.irWrite = 1; r.pcWrite = 1;
        plan.push_back(mkStep(1, o, r, 0));
        plan.push_back(mkStep(0, z, z, 0));
        case (op)
            6'h00: begin
                if (fn == 6'h08) begin
                    o = z; o.pcWrite = 1; o.pcSrc = 2'd3;
                    plan.push_back(mkStep(0, o, z, 0));
                end else begin
                    o = z; o.ALUOp = 2'd2; o.regDst = 2'd1;
                    plan.push_back(mkStep(0, o, z, 0));
                    if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
                        o.regWrite = 1; o.regSrc = 2'd2;
                        plan.push_back(mkStep(0, o, z, 0));
                    end else begin
                        planRetires = 0;
                        planIllegal = 1;
                    end
                end
            end
            6'h08: begin
                o = z; o.ALUSrc = 1;
                plan.push_back(mkStep(0, o, z, 0));
                o.regWrite = 1; o.regSrc = 2'd2;
                plan.push_back(mkStep(0, o, z, 0));
            end
            6'h23: begin
                o = z; o.ALUSrc = 1;
                plan.push_back(mkStep(0, o, z, 0));
                o.memReq = 1;
                plan.push_back(mkStep(1, o, z, 0));
                o = z; o.regWrite = 1; o.regSrc = 2'd1;
                plan.push_back(mkStep(0, o, z, 0));
            end
            6'h2B: begin
                o = z; o.ALUSrc = 1;
                plan.push_back(mkStep(0, o, z, 0));
                o.memReq = 1;
                r = z; r.memWrite = 1;
                plan.push_back(mkStep(1, o, r, 0));
            end
            6'h04, 6'h05: begin
                o = z; o.ALUOp = 2'd1; o.pcSrc = 2'd1;
                plan.push_back(mkStep(0, o, z, (op == 6'h04) ? 1 : 2));
            end
            6'h02, 6'h03: begin
                o = z; o.pcWrite = 1; o.pcSrc = 2'd2;
                if (op == 6'h03) begin
                    o.regWrite = 1; o.regDst = 2'd2; o.regSrc = 2'd0;
                end
                plan.push_back(mkStep(0, o, z, 0));
            end
            default: begin
                planRetires = 0;
                planIllegal = 1;
            end
        endcase
    endtask

    // lowCycles applies to the data-memory step when randReady is 0; forceZero<0 means random.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int lowCycles,
                            input bit randReady, input int forceZero,
                            output int cycles, output int mw, output int rw, output int pw);
        outs_t e;
        int    lows;
        bit    done;
        buildPlan(op, fn);
        opcode = op;
        funct  = fn;
        cycles = 0; mw = 0; rw = 0; pw = 0;
        for (int i = 0; i < plan.size(); i++) begin
            lows = 0;
            do begin
                if (plan[i].waitMem) begin
                    if (randReady) memReady = (lows >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    else           memReady = (i >= 2 && lows < lowCycles) ? 1'b0 : 1'b1;
                end else begin
                    memReady = 1'($urandom_range(0, 1));
                end
                zero = (forceZero < 0) ? 1'($urandom_range(0, 1)) : 1'(forceZero);
                e = plan[i].o;
                if (plan[i].waitMem && memReady) e = e | plan[i].onReady;
                if (plan[i].zeroRule == 1) e.pcWrite = zero;
                if (plan[i].zeroRule == 2) e.pcWrite = !zero;
                expOut  = e;
                checkEn = 1;
                @(negedge clk);
                if (memWrite) mw++;
                if (regWrite) rw++;
                if (pcWrite)  pw++;
                @(posedge clk);
                #1;
                cycles++;
                done = !plan[i].waitMem || memReady;
                if (!done) lows++;
            end while (!done);
        end
        if (planRetires) expRetired = expRetired + 1'b1;
        if (planIllegal) expIllegal = 1'b1;
    endtask

    logic [5:0] opTable [11] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03, 6'h3F, 6'h11};
    logic [5:0] fnTable [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h03};

    task automatic runRandom(input int n);
        int c, mw, rw, pw;
        for (int k = 0; k < n; k++) begin
            runInstr(opTable[$urandom_range(0, 10)], fnTable[$urandom_range(0, 6)],
                     0, 1, -1, c, mw, rw, pw);
        end
    endtask

    initial begin
        int c, mw, rw, pw;
        rst = 1; opcode = '0; funct = '0; zero = 0; memReady = 0;
        expRetired = '0; expIllegal = 0;
        #1;
        check("rst outputs idle", 32'(dutOut), 32'd0);
        check("rst retired", 32'(retired), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        memReady = 1;
        #1;
        check("rst outputs idle ready", 32'(dutOut), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        runInstr(6'h00, 6'h20, 0, 0, -1, c, mw, rw, pw);
        check("add cycles", c, 4);
        check("add regWrite pulses", rw, 1);
        check("add retired", 32'(retired), 1);

        runInstr(6'h23, 6'h00, 2, 0, -1, c, mw, rw, pw);
        check("lw cycles", c, 7);
        check("lw memWrite pulses", mw, 0);
        check("lw regWrite pulses", rw, 1);

        runInstr(6'h2B, 6'h00, 0, 0, -1, c, mw, rw, pw);
        check("sw cycles", c, 4);
        check("sw memWrite pulses", mw, 1);
        check("sw regWrite pulses", rw, 0);

        runInstr(6'h04, 6'h00, 0, 0, 1, c, mw, rw, pw);
        check("beq cycles", c, 3);
        check("beq pcWrite pulses", pw, 2);
        runInstr(6'h05, 6'h00, 0, 0, 1, c, mw, rw, pw);
        check("bne pcWrite pulses", pw, 1);
        check("branch retired", 32'(retired), 5);

        runInstr(6'h03, 6'h00, 0, 0, -1, c, mw, rw, pw);
        check("jal cycles", c, 3);
        check("jal regWrite pulses", rw, 1);
        runInstr(6'h00, 6'h08, 0, 0, -1, c, mw, rw, pw);
        check("jr cycles", c, 3);

        runInstr(6'h3F, 6'h00, 0, 0, -1, c, mw, rw, pw);
        check("bad opcode cycles", c, 2);
        check("bad opcode illegal", 32'(illegal), 1);
        check("bad opcode retired", 32'(retired), 7);
        runInstr(6'h00, 6'h03, 0, 0, -1, c, mw, rw, pw);
        check("bad funct cycles", c, 3);

        runRandom(150);

        // Abort a store stalled in its memory phase.
        checkEn = 0;
        opcode = 6'h2B; funct = '0; memReady = 1;
        @(posedge clk); #1;
        memReady = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sw stalled memReq", 32'(memReq), 1);
        check("sw stalled memWrite", 32'(memWrite), 0);
        #2;
        rst = 1;
        memReady = 1;
        #1;
        check("mid rst outputs idle", 32'(dutOut), 32'd0);
        check("mid rst retired", 32'(retired), 0);
        check("mid rst illegal", 32'(illegal), 0);
        @(posedge clk); #1;
        check("mid rst memWrite", 32'(memWrite), 0);
        #3;
        rst = 0;
        expRetired = '0;
        expIllegal = 0;

        runRandom(40);

        checkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
